// File: rtl/muldiv_unit_pkg.sv
// Shared constants, control payload and helpers for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Per-instruction control captured when the op is accepted
  typedef struct packed {
    logic mul_lo;
    logic sign_a;
    logic sign_b;
    logic is_rem;
    logic neg_quo;
    logic neg_rem;
  } muldiv_ctl_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, done WIDTH cycles after start.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] first_step;
  logic [2*WIDTH-1:0] next_step;

  // Shift in the next dividend bit; subtract if it fits. Returns {rem, quo}.
  function automatic logic [2*WIDTH-1:0] restore_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  // The load cycle already performs the first iteration
  assign first_step = restore_step('0, dividend, divisor);
  assign next_step  = restore_step(rem_q, quo_q, divisor_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy           <= 1'b1;
        cnt            <= CNT_W'(WIDTH - 1);
        divisor_q      <= divisor;
        {rem_q, quo_q} <= first_step;
      end else if (busy) begin
        {rem_q, quo_q} <= next_step;
        cnt            <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage unit: 2-cycle multiplier, restoring divider, special-case shortcuts.
import muldiv_unit_pkg::*;

module muldiv_unit (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  state_t            next_state;
  muldiv_ctl_t       ctl_d;
  muldiv_ctl_t       ctl_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              is_div;
  logic              is_signed;
  logic              by_zero;
  logic              overflow;
  logic              capture;
  logic              load_result;
  logic              div_start;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic signed [XLEN:0] mul_a;
  logic signed [XLEN:0] mul_b;
  logic signed [PW-1:0] prod;
  logic              div_busy;
  logic              div_done;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;

  // Decode of the instruction currently in EX
  always_comb begin
    ctl_d     = '0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (funct3)
      FUNCT3_MUL:    ctl_d.mul_lo = 1'b1;
      FUNCT3_MULH:   begin ctl_d.sign_a = 1'b1; ctl_d.sign_b = 1'b1; end
      FUNCT3_MULHSU: ctl_d.sign_a = 1'b1;
      FUNCT3_MULHU:  begin end
      FUNCT3_DIV:    begin is_div = 1'b1; is_signed = 1'b1; end
      FUNCT3_DIVU:   is_div = 1'b1;
      FUNCT3_REM:    begin is_div = 1'b1; is_signed = 1'b1; ctl_d.is_rem = 1'b1; end
      FUNCT3_REMU:   begin is_div = 1'b1; ctl_d.is_rem = 1'b1; end
      default:       begin end
    endcase
    ctl_d.neg_quo = is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
    ctl_d.neg_rem = is_signed & op_a[XLEN-1];
  end

  assign by_zero     = (op_b == '0);
  assign overflow    = is_signed && (op_a == INT_MIN) && (op_b == '1);
  assign special_res = ctl_d.is_rem ? (by_zero ? op_a : '0) : (by_zero ? '1 : INT_MIN);
  assign mag_a       = neg_if(op_a, ctl_d.neg_rem);
  assign mag_b       = neg_if(op_b, is_signed & op_b[XLEN-1]);

  // Low 64 bits of the 33x33 signed product are all that any MUL variant needs
  assign mul_a = {ctl_q.sign_a & a_q[XLEN-1], a_q};
  assign mul_b = {ctl_q.sign_b & b_q[XLEN-1], b_q};
  assign prod  = PW'(mul_a) * PW'(mul_b);

  div_core #(.WIDTH(XLEN)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    load_result = 1'b0;
    load_val    = '0;
    div_start   = 1'b0;
    case (state)
      IDLE: begin
        if (m_valid) begin
          capture = 1'b1;
          if (!is_div) begin
            next_state = MUL;
          end else if (by_zero || overflow) begin
            next_state  = DONE;
            load_result = 1'b1;
            load_val    = special_res;
          end else begin
            next_state = DIV;
            div_start  = 1'b1;
          end
        end
      end
      MUL: begin
        if (!m_valid) begin
          next_state = IDLE;
        end else begin
          next_state  = DONE;
          load_result = 1'b1;
          load_val    = ctl_q.mul_lo ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        end
      end
      DIV: begin
        if (!m_valid) begin
          next_state = IDLE;
        end else if (div_done) begin
          next_state  = DONE;
          load_result = 1'b1;
          load_val    = ctl_q.is_rem ? neg_if(div_rem, ctl_q.neg_rem)
                                     : neg_if(div_quo, ctl_q.neg_quo);
        end else if (!div_busy) begin
          next_state = IDLE;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= load_result;
      if (capture) begin
        ctl_q <= ctl_d;
        a_q   <= op_a;
        b_q   <= op_b;
      end
      if (load_result) result <= load_val;
    end
  end

  // DONE releases the pipeline; reset must never leave a stall asserted
  assign stall = m_valid && (state != DONE) && !rst;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: latency/result model checked every cycle plus directed literal checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  muldiv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .m_valid      (m_valid),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no result_valid within cycle budget", name);
  endtask

  // Architectural result of an M instruction
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Stall cycles before the result cycle
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4) return 2;
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  typedef enum {P_IDLE, P_BUSY, P_DONE} phase_t;
  phase_t      phase = P_IDLE;
  int          remaining = 0;
  logic [31:0] exp_res = '0;
  logic        exp_stall;
  logic        exp_valid;

  // Per-cycle compare against the latency/result model
  always @(negedge clk) begin
    if (result_valid) pulse_cnt++;
    if (rst) begin
      chk("stall_in_reset", {31'd0, stall}, 32'd0);
      phase = P_IDLE;
    end else begin
      exp_stall = 1'b0;
      exp_valid = 1'b0;
      case (phase)
        P_IDLE: begin
          if (m_valid) begin
            exp_stall = 1'b1;
            exp_res   = model_res(funct3, op_a, op_b);
            remaining = model_lat(funct3, op_a, op_b) - 1;
            phase     = (remaining == 0) ? P_DONE : P_BUSY;
          end
        end
        P_BUSY: begin
          if (!m_valid) begin
            phase = P_IDLE;
          end else begin
            exp_stall = 1'b1;
            remaining--;
            if (remaining == 0) phase = P_DONE;
          end
        end
        default: begin
          exp_valid = 1'b1;
          phase     = P_IDLE;
        end
      endcase
      chk("cyc_stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("cyc_result_valid", {31'd0, result_valid}, {31'd0, exp_valid});
      if (exp_valid) chk("cyc_result", result, exp_res);
    end
  end

  task automatic wait_pulse(output int stalls, output int cycles, output bit got);
    stalls = 0;
    cycles = 0;
    got    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      if (stall) stalls++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int  stalls, cycles;
    bit  got;
    @(posedge clk); #1;
    m_valid = 1'b1; funct3 = f3; op_a = a; op_b = b;
    wait_pulse(stalls, cycles, got);
    if (!got) begin
      fail_now(name);
    end else begin
      chk({name, "_result"}, result, exp);
      chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  stalls, cycles, p0;
    bit  got;
    rst = 1'b1; m_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    run_op("mul_7_m3",       3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulh_min_m1",    3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    run_op("mulhsu_min_m1",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("mulhu_min_m1",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2);
    run_op("mulhu_max_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu_100_0",     3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_min_m1",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("div_min_m1",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_m7_0",       3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
    run_op("divu_max_3",     3'd5, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 33);
    run_op("remu_100_7",     3'd7, 32'd100,       32'd7,         32'd2,         33);
    run_op("div_20_m6",      3'd4, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 33);
    run_op("rem_20_m6",      3'd6, 32'd20,        32'hFFFF_FFFA, 32'd2,         33);

    // DIVU then MUL with m_valid held high throughout
    @(posedge clk); #1;
    p0 = pulse_cnt;
    m_valid = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    wait_pulse(stalls, cycles, got);
    if (!got) fail_now("b2b_divu");
    else chk("b2b_divu_result", result, 32'd14);
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7;
    wait_pulse(stalls, cycles, got);
    if (!got) begin
      fail_now("b2b_mul");
    end else begin
      chk("b2b_mul_result", result, 32'd42);
      chk("b2b_pulse_gap", 32'(cycles), 32'd3);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("b2b_pulse_count", 32'(pulse_cnt - p0), 32'd2);

    // m_valid withdrawn mid-divide: operation abandoned silently
    @(posedge clk); #1;
    m_valid = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    m_valid = 1'b0;
    p0 = pulse_cnt;
    repeat (40) @(negedge clk);
    chk("drop_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    // Reset 10 cycles into a divide
    @(posedge clk); #1;
    m_valid = 1'b1; funct3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    chk("rst_stall_forced", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    chk("rst_result_cleared", result, 32'd0);
    chk("rst_stall_after", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    chk("rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    run_op("div_after_rst",  3'd4, 32'd1000,      32'd3,         32'd333,       33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
